// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants for the single-cycle RV64I-subset core.
//   XLEN        - datapath width (64)
//   OP_*        - major opcodes the core recognises
//   F3_* / F7_* - funct3/funct7 values used by the decoder
//   alu_op_e    - 2-bit ALU operation select
package riscv_pkg;

  localparam int XLEN = 64;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_DOUBLE  = 3'b011;
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_OR      = 3'b110;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

endpackage

// File: rtl/alu.sv
// alu: 64-bit combinational ALU, results wrap modulo 2^64.
//   a, b   - operands
//   op     - operation select (alu_op_e)
//   result - operation result
//   zero   - high when result is all zeros (used by beq)
module alu
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_e         op,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/id_stage.sv
// id_stage: 32 x 64-bit register file, two combinational read ports and one
// write port committed on the rising clock edge.
//   clk, reset            - clock; synchronous active-high reset clears all regs
//   rs1, rs2              - read addresses
//   reg_write, write_reg,
//   write_data            - write enable, address and data
//   read_data1/2          - read data (x0 always reads zero)
module id_stage
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic            reg_write,
  input  logic [4:0]      write_reg,
  input  logic [XLEN-1:0] write_data,
  output logic [XLEN-1:0] read_data1,
  output logic [XLEN-1:0] read_data2
);

  logic [XLEN-1:0] registers [32];

  // Reset wins over a write retiring on the same edge; x0 is never written.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) registers[i] <= '0;
    end else if (reg_write && (write_reg != 5'd0)) begin
      registers[write_reg] <= write_data;
    end
  end

  assign read_data1 = (rs1 == 5'd0) ? '0 : registers[rs1];
  assign read_data2 = (rs2 == 5'd0) ? '0 : registers[rs2];

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction ROM with combinational fetch.
//   addr        - word index (PC bits above the byte offset); IMEM_DEPTH
//                 must be a power of two so the index wraps naturally
//   instruction - 32-bit instruction word at addr
// instr_mem is preloaded hierarchically by whoever owns the simulation.
module if_stage
  import riscv_pkg::*;
#(
  parameter int IMEM_DEPTH = 256
) (
  input  logic [$clog2(IMEM_DEPTH)-1:0] addr,
  output logic [31:0]                   instruction
);

  logic [31:0] instr_mem [IMEM_DEPTH];

  assign instruction = instr_mem[addr];

endmodule

// File: rtl/mem_stage.sv
// mem_stage: doubleword data RAM, combinational read, write on rising edge.
//   clk, reset  - clock; reset suppresses a store but does not clear the RAM
//   mem_read    - load in progress (read data is zero otherwise)
//   mem_write   - store enable
//   addr        - doubleword index (byte address bits above the low three);
//                 DMEM_DEPTH must be a power of two so the index wraps
//   write_data  - store data
//   read_data   - load data
module mem_stage
  import riscv_pkg::*;
#(
  parameter int DMEM_DEPTH = 256
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          mem_read,
  input  logic                          mem_write,
  input  logic [$clog2(DMEM_DEPTH)-1:0] addr,
  input  logic [XLEN-1:0]               write_data,
  output logic [XLEN-1:0]               read_data
);

  logic [XLEN-1:0] mem [DMEM_DEPTH];

  always_ff @(posedge clk) begin
    if (mem_write && !reset) mem[addr] <= write_data;
  end

  assign read_data = mem_read ? mem[addr] : '0;

endmodule

// File: rtl/single_cycle_processor.sv
// single_cycle_processor: single-cycle RV64I-subset core (ld, sd, add, beq).
// Each instruction is fetched, decoded, executed, memory-accessed and
// written back within one clock; PC, register and store updates all land on
// the same rising edge.
//   clk   - sole clock
//   reset - synchronous active-high; clears PC and register file
// Build option: define RV_ALU_EXT_EN to also decode sub, and, or and addi;
// without it those encodings retire as NOPs.
module single_cycle_processor
  import riscv_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input  logic clk,
  input  logic reset
);

  localparam int IW = $clog2(IMEM_DEPTH);
  localparam int DW = $clog2(DMEM_DEPTH);

  logic [XLEN-1:0] pc_current;
  logic [XLEN-1:0] pc_next;
  logic [31:0]     instruction;
  logic [XLEN-1:0] read_data1;
  logic [XLEN-1:0] read_data2;
  logic [XLEN-1:0] imm_ext;
  logic            reg_write;
  logic            alu_src;
  alu_op_e         alu_op;
  logic            branch;
  logic            mem_read;
  logic            mem_write;
  logic            mem_to_reg;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_result;
  logic            zero;
  logic            branch_taken;
  logic [XLEN-1:0] alu_result_mem;
  logic [XLEN-1:0] read_data_mem;
  logic [4:0]      write_reg;
  logic [XLEN-1:0] write_data_reg;
  logic            reg_write_wb;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];

  if_stage #(.IMEM_DEPTH(IMEM_DEPTH)) if_stage (
    .addr        (pc_current[IW+1:2]),
    .instruction (instruction)
  );

  // Anything not matched here leaves every control line low, so unknown
  // encodings fall through as NOPs with PC+4.
  always_comb begin
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    branch     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    case (opcode)
      OP_LOAD: begin
        if (funct3 == F3_DOUBLE) begin
          reg_write  = 1'b1;
          alu_src    = 1'b1;
          mem_read   = 1'b1;
          mem_to_reg = 1'b1;
        end
      end
      OP_STORE: begin
        if (funct3 == F3_DOUBLE) begin
          alu_src   = 1'b1;
          mem_write = 1'b1;
        end
      end
      OP_REG: begin
        if (funct3 == F3_ADD_SUB && funct7 == F7_BASE) begin
          reg_write = 1'b1;
        end
`ifdef RV_ALU_EXT_EN
        else if (funct3 == F3_ADD_SUB && funct7 == F7_SUB) begin
          reg_write = 1'b1;
          alu_op    = ALU_SUB;
        end else if (funct3 == F3_AND && funct7 == F7_BASE) begin
          reg_write = 1'b1;
          alu_op    = ALU_AND;
        end else if (funct3 == F3_OR && funct7 == F7_BASE) begin
          reg_write = 1'b1;
          alu_op    = ALU_OR;
        end
`endif
      end
      OP_BRANCH: begin
        if (funct3 == F3_BEQ) begin
          branch = 1'b1;
          alu_op = ALU_SUB;
        end
      end
`ifdef RV_ALU_EXT_EN
      OP_IMM: begin
        if (funct3 == F3_ADD_SUB) begin
          reg_write = 1'b1;
          alu_src   = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  // Immediate format follows the opcode; branch offsets have an implicit 0 LSB.
  always_comb begin
    imm_ext = '0;
    case (opcode)
      OP_LOAD, OP_IMM: imm_ext = {{52{instruction[31]}}, instruction[31:20]};
      OP_STORE:        imm_ext = {{52{instruction[31]}}, instruction[31:25],
                                  instruction[11:7]};
      OP_BRANCH:       imm_ext = {{51{instruction[31]}}, instruction[31],
                                  instruction[7], instruction[30:25],
                                  instruction[11:8], 1'b0};
      default:         imm_ext = '0;
    endcase
  end

  assign write_reg    = instruction[11:7];
  assign reg_write_wb = reg_write;

  id_stage id_stage (
    .clk        (clk),
    .reset      (reset),
    .rs1        (instruction[19:15]),
    .rs2        (instruction[24:20]),
    .reg_write  (reg_write_wb),
    .write_reg  (write_reg),
    .write_data (write_data_reg),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  assign alu_b = alu_src ? imm_ext : read_data2;

  alu alu_inst (
    .a      (read_data1),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_result),
    .zero   (zero)
  );

  assign branch_taken   = branch & zero;
  assign alu_result_mem = alu_result;

  mem_stage #(.DMEM_DEPTH(DMEM_DEPTH)) mem_stage (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .addr       (alu_result_mem[DW+2:3]),
    .write_data (read_data2),
    .read_data  (read_data_mem)
  );

  assign write_data_reg = mem_to_reg ? read_data_mem : alu_result;
  assign pc_next        = branch_taken ? (pc_current + imm_ext) : (pc_current + 64'd4);

  always_ff @(posedge clk) begin
    if (reset) pc_current <= '0;
    else       pc_current <= pc_next;
  end

endmodule

// File: tb/tb_single_cycle_processor.sv
// tb_single_cycle_processor: drives the core one instruction per cycle by
// writing the ROM word at the model's PC, predicts the architectural effect
// with an instruction-level model, and queues the prediction; a monitor pops
// one prediction after every rising edge and compares PC, register file and
// memory. Build with RV_ALU_EXT_EN to exercise the extended ALU encodings.
module tb_single_cycle_processor;

  localparam int IMEM = 256;
  localparam int DMEM = 256;
`ifdef RV_ALU_EXT_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  typedef enum int {K_LD, K_SD, K_ADD, K_SUB, K_AND, K_OR, K_ADDI, K_BEQ, K_NOP} kind_e;

  typedef struct {
    int          step;
    logic [63:0] pc;
    logic [63:0] sig;
    bit          chkRd;
    int          rd;
    logic [63:0] rdVal;
    bit          chkMem;
    int          midx;
    logic [63:0] mval;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [63:0] mregs [32];
  logic [63:0] mmem [DMEM];
  logic [63:0] mpc;
  exp_t        sbq [$];
  int          stepNo = 0;
  int          testsRun = 0;
  int          testsFailed = 0;

  always #5 clk = ~clk;

  single_cycle_processor #(.IMEM_DEPTH(IMEM), .DMEM_DEPTH(DMEM)) dut (
    .clk   (clk),
    .reset (reset)
  );

  function automatic logic [31:0] encR(input logic [6:0] f7, input int rs2, input int rs1,
                                       input logic [2:0] f3, input int rd, input logic [6:0] op);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), op};
  endfunction

  function automatic logic [31:0] encI(input logic [11:0] imm, input int rs1,
                                       input logic [2:0] f3, input int rd, input logic [6:0] op);
    return {imm, 5'(rs1), f3, 5'(rd), op};
  endfunction

  function automatic logic [31:0] encS(input logic [11:0] imm, input int rs2, input int rs1);
    return {imm[11:5], 5'(rs2), 5'(rs1), 3'b011, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] encB(input logic [12:0] imm, input int rs2, input int rs1);
    return {imm[12], imm[10:5], 5'(rs2), 5'(rs1), 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [63:0] foldRegs(input logic [63:0] r [32]);
    logic [63:0] s = 64'h0;
    for (int i = 0; i < 32; i++) s = {s[58:0], s[63:59]} ^ r[i];
    return s;
  endfunction

  task automatic setReg(input int i, input logic [63:0] v);
    dut.id_stage.registers[i] = v;
    mregs[i] = v;
  endtask

  task automatic setMem(input int i, input logic [63:0] v);
    dut.mem_stage.mem[i] = v;
    mmem[i] = v;
  endtask

  // Issue one instruction for the coming edge and queue its expected effect.
  task automatic applyStimulus(input logic [31:0] word, input kind_e kindIn, input int rd,
                               input int rs1, input int rs2, input logic [63:0] imm,
                               input bit rst);
    exp_t        e;
    kind_e       k;
    logic [63:0] a, b, addr, wval, npc;
    bit          wr;
    int          idx;
    reset = rst;
    dut.if_stage.instr_mem[int'((mpc >> 2) % IMEM)] = word;
    k = kindIn;
    if (!EXT && (k == K_SUB || k == K_AND || k == K_OR || k == K_ADDI)) k = K_NOP;
    a = mregs[rs1];
    b = mregs[rs2];
    addr = a + imm;
    idx = int'((addr >> 3) % DMEM);
    npc = mpc + 64'd4;
    wr = 1'b0;
    wval = 64'h0;
    e.step = stepNo;
    e.chkRd = 1'b0;
    e.rd = 0;
    e.rdVal = 64'h0;
    e.chkMem = 1'b0;
    e.midx = 0;
    e.mval = 64'h0;
    case (k)
      K_LD:   begin wr = 1'b1; wval = mmem[idx]; end
      K_SD:   begin
        mmem[idx] = b;
        e.chkMem = 1'b1;
        e.midx = idx;
        e.mval = b;
      end
      K_ADD:  begin wr = 1'b1; wval = a + b; end
      K_SUB:  begin wr = 1'b1; wval = a - b; end
      K_AND:  begin wr = 1'b1; wval = a & b; end
      K_OR:   begin wr = 1'b1; wval = a | b; end
      K_ADDI: begin wr = 1'b1; wval = a + imm; end
      K_BEQ:  if (a == b) npc = mpc + imm;
      default: ;
    endcase
    if (rst) begin
      for (int i = 0; i < 32; i++) mregs[i] = 64'h0;
      npc = 64'h0;
    end else if (wr) begin
      if (rd != 0) mregs[rd] = wval;
      e.chkRd = 1'b1;
      e.rd = rd;
      e.rdVal = (rd == 0) ? 64'h0 : wval;
    end
    mpc = npc;
    e.pc = npc;
    e.sig = foldRegs(mregs);
    sbq.push_back(e);
    stepNo++;
  endtask

  task automatic checkOutput(input exp_t e);
    logic [63:0] r [32];
    logic [63:0] got;
    for (int i = 0; i < 32; i++) r[i] = dut.id_stage.registers[i];
    testsRun++;
    if (dut.pc_current !== e.pc) begin
      testsFailed++;
      $display("[TB] FAIL step%0d pc: got %h expected %h", e.step, dut.pc_current, e.pc);
    end
    testsRun++;
    got = foldRegs(r);
    if (got !== e.sig) begin
      testsFailed++;
      $display("[TB] FAIL step%0d regfile signature: got %h expected %h", e.step, got, e.sig);
    end
    if (e.chkRd) begin
      testsRun++;
      if (r[e.rd] !== e.rdVal) begin
        testsFailed++;
        $display("[TB] FAIL step%0d x%0d: got %h expected %h", e.step, e.rd, r[e.rd], e.rdVal);
      end
    end
    if (e.chkMem) begin
      testsRun++;
      got = dut.mem_stage.mem[e.midx];
      if (got !== e.mval) begin
        testsFailed++;
        $display("[TB] FAIL step%0d mem[%0d]: got %h expected %h", e.step, e.midx, got, e.mval);
      end
    end
  endtask

  // Monitor: every edge retires exactly one queued instruction.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) checkOutput(sbq.pop_front());
    end
  end

  initial begin
    kind_e       k;
    int          rd, rs1, rs2, sel;
    logic [11:0] imm12;
    logic [12:0] bimm;
    logic [63:0] immv;
    logic [31:0] word;

    mpc = 64'h0;
    for (int i = 0; i < 32; i++) mregs[i] = 64'h0;
    for (int i = 0; i < DMEM; i++) setMem(i, {$urandom(), $urandom()});

    // Reset held across two issued edges; PC and registers must read zero.
    repeat (2) begin
      @(negedge clk);
      applyStimulus(encR(7'h00, 2, 1, 3'b000, 3, 7'b0110011), K_ADD, 3, 1, 2, 64'h0, 1'b1);
    end

    @(negedge clk);
    setReg(14, 64'h100);
    setMem(32, 64'h1234567890ABCDEF);
    applyStimulus(32'h00073A03, K_LD, 20, 14, 0, 64'h0, 1'b0);

    @(negedge clk);
    setReg(5, 64'd5);
    setReg(6, 64'd6);
    applyStimulus(32'h00530AB3, K_ADD, 21, 6, 5, 64'h0, 1'b0);

    @(negedge clk);
    applyStimulus(encR(7'h00, 5, 6, 3'b000, 0, 7'b0110011), K_ADD, 0, 6, 5, 64'h0, 1'b0);

    @(negedge clk);
    setReg(17, 64'd1);
    setReg(18, 64'd1);
    applyStimulus(32'h01288863, K_BEQ, 0, 17, 18, 64'd16, 1'b0);

    @(negedge clk);
    setReg(16, 64'h200);
    applyStimulus(32'h01583023, K_SD, 0, 16, 21, 64'h0, 1'b0);

    @(negedge clk);
    setReg(18, 64'd2);
    applyStimulus(32'h01288863, K_BEQ, 0, 17, 18, 64'd16, 1'b0);

    @(negedge clk);
    setReg(1, 64'h55);
    applyStimulus(32'hFFF00093, K_ADDI, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

    @(negedge clk);
    applyStimulus(32'h0000007F, K_NOP, 0, 0, 0, 64'h0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) setReg(int'($urandom_range(1, 31)), {$urandom(), $urandom()});
      k = kind_e'($urandom_range(0, 8));
      rd = int'($urandom_range(0, 31));
      rs1 = int'($urandom_range(0, 31));
      rs2 = int'($urandom_range(0, 31));
      imm12 = 12'($urandom_range(0, 4095));
      immv = {{52{imm12[11]}}, imm12};
      word = 32'h0;
      case (k)
        K_LD:   word = encI(imm12, rs1, 3'b011, rd, 7'b0000011);
        K_SD:   word = encS(imm12, rs2, rs1);
        K_ADD:  word = encR(7'h00, rs2, rs1, 3'b000, rd, 7'b0110011);
        K_SUB:  word = encR(7'h20, rs2, rs1, 3'b000, rd, 7'b0110011);
        K_AND:  word = encR(7'h00, rs2, rs1, 3'b111, rd, 7'b0110011);
        K_OR:   word = encR(7'h00, rs2, rs1, 3'b110, rd, 7'b0110011);
        K_ADDI: word = encI(imm12, rs1, 3'b000, rd, 7'b0010011);
        K_BEQ: begin
          if ($urandom_range(0, 1) == 1) rs2 = rs1;
          bimm = 13'($urandom_range(0, 2047)) << 2;
          immv = {{51{bimm[12]}}, bimm};
          word = encB(bimm, rs2, rs1);
        end
        default: begin
          sel = int'($urandom_range(0, 2));
          if (sel == 0)      word = encR(7'h00, rs2, rs1, 3'b001, rd, 7'b0110011);
          else if (sel == 1) word = encI(imm12, rs1, 3'b010, rd, 7'b0000011);
          else               word = encI(imm12, rs1, 3'b000, rd, 7'b1101111);
        end
      endcase
      applyStimulus(word, k, rd, rs1, rs2, immv, 1'b0);
    end

    // Reset must win over an add retiring on the same edge.
    @(negedge clk);
    setReg(1, 64'd7);
    setReg(2, 64'd9);
    applyStimulus(encR(7'h00, 2, 1, 3'b000, 3, 7'b0110011), K_ADD, 3, 1, 2, 64'h0, 1'b1);

    @(negedge clk);
    setReg(4, 64'd40);
    applyStimulus(encR(7'h00, 4, 4, 3'b000, 9, 7'b0110011), K_ADD, 9, 4, 4, 64'h0, 1'b0);

    for (int w = 0; w < 10 && sbq.size() > 0; w++) @(negedge clk);
    if (sbq.size() > 0) begin
      testsFailed++;
      $display("[TB] FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
